// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters,
// screening illegal commands and divide/modulo by zero before the ALU is enabled.
module alu_req_arbiter #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [IN_WIDTH-1:0]  r0_a,
  input  logic [IN_WIDTH-1:0]  r0_b,
  input  logic [7:0]           r0_cmd,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [IN_WIDTH-1:0]  r1_a,
  input  logic [IN_WIDTH-1:0]  r1_b,
  input  logic [7:0]           r1_cmd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [OUT_WIDTH-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [IN_WIDTH-1:0]  alu_a,
  output logic [IN_WIDTH-1:0]  alu_b,
  output logic [7:0]           alu_cmd,
  output logic                 alu_oe,
  input  logic [OUT_WIDTH-1:0] alu_result,
  output logic [CNT_WIDTH-1:0] done_count
);

  // state  | meaning
  // S_IDLE | arbitrate, accept one request
  // S_EXEC | ALU driven from operation registers, result captured at end
  // S_RESP | response held until consumer takes it
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_id;
  logic                  r_err;
  logic [IN_WIDTH-1:0]   r_alu_a;
  logic [IN_WIDTH-1:0]   r_alu_b;
  logic [7:0]            r_alu_cmd;
  logic                  r_alu_oe;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [OUT_WIDTH-1:0]  r_rsp_data;
  logic                  r_rsp_err;
  logic [CNT_WIDTH-1:0]  r_done_count;

  logic                  w_idle;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  logic [IN_WIDTH-1:0]   w_a;
  logic [IN_WIDTH-1:0]   w_b;
  logic [7:0]            w_cmd;
  logic                  w_illegal;
  logic                  w_divz;
  logic                  w_err;

  // last_grant=1 favours requester 0 on a tie, and vice versa
  assign w_idle   = (r_state == S_IDLE) & ~rst;
  assign w_gnt0   = w_idle & r0_valid & (~r1_valid | r_last_grant);
  assign w_gnt1   = w_idle & r1_valid & (~r0_valid | ~r_last_grant);
  assign w_accept = w_gnt0 | w_gnt1;

  assign w_a   = w_gnt1 ? r1_a   : r0_a;
  assign w_b   = w_gnt1 ? r1_b   : r0_b;
  assign w_cmd = w_gnt1 ? r1_cmd : r0_cmd;

  // legal codes are 0x00-0x07 and 0x80-0x87: bits [6:3] must be clear
  assign w_illegal = (w_cmd[6:3] != 4'd0);
  assign w_divz    = ((w_cmd == 8'h03) || (w_cmd == 8'h06)) && (w_b == '0);
  assign w_err     = w_illegal | w_divz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cmd    <= '0;
      r_alu_oe     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_a;
            r_alu_b      <= w_b;
            r_alu_cmd    <= w_cmd;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_err        <= w_err;
            r_alu_oe     <= ~w_err;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= r_err ? '0 : alu_result;
          r_rsp_err   <= r_err;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_alu_oe    <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= r_done_count + CNT_WIDTH'(1);
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r0_ready   = w_gnt0;
  assign r1_ready   = w_gnt1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cmd    = r_alu_cmd;
  assign alu_oe     = r_alu_oe;
  assign done_count = r_done_count;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 8-bit ALU (16-op, 8-bit command codes, output-enable gated, 16-bit result) between two requesters.
- Provides round-robin arbitration, a valid/ready request handshake per requester and one shared tagged response channel.
- Screens illegal commands and divide/modulo by zero so the ALU is never driven for them.
- Sits between the two issuing agents and the ALU instance.

Parameters:
IN_WIDTH, 8, operand width for a/b.
OUT_WIDTH, 16, ALU result width.
CNT_WIDTH, 16, width of completed-operation counter.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
r0_valid  input  1  requester 0 has an operation
r0_ready  output  1  requester 0 operation accepted this cycle when r0_valid=1
r0_a  input  IN_WIDTH  requester 0 operand A
r0_b  input  IN_WIDTH  requester 0 operand B
r0_cmd  input  8  requester 0 ALU command code
r1_valid, r1_ready, r1_a, r1_b, r1_cmd  same as requester 0, for requester 1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that issued the operation
rsp_data  output  OUT_WIDTH  captured ALU result
rsp_err  output  1  1 = illegal command or divide/modulo by zero
alu_a  output  IN_WIDTH  to ALU a_in
alu_b  output  IN_WIDTH  to ALU b_in
alu_cmd  output  8  to ALU command_in
alu_oe  output  1  to ALU oe
alu_result  input  OUT_WIDTH  from ALU alu_out
done_count  output  CNT_WIDTH  number of responses consumed

Behaviour:
- Legal command codes:
  - 0x00-0x07: ADD, SUB, MUL, DIV, INC, DEC, MOD, LT.
  - 0x80-0x87: AND, OR, XOR, NOT, LSH, RSH, EQ, NEQ.
  - Any other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational.
  - If only one requester is valid, it is granted.
  - If both are valid, grant the requester that is not last_grant.
  - rX_ready = (state==IDLE) & grantX. At most one ready is high at a time; both are 0 outside IDLE.
- Accept (rX_valid & rX_ready) at edge T:
  - Latch a, b, cmd and id into operation registers.
  - last_grant <= id.
  - err_q <= illegal cmd, or (cmd is DIV or MOD and b==0).
  - Go to EXEC.
- EXEC (one cycle):
  - alu_a, alu_b, alu_cmd driven from operation registers.
  - alu_oe = ~err_q.
  - At the end edge: rsp_data <= err_q ? 0 : alu_result; rsp_err <= err_q; rsp_id <= id. Go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: go to IDLE and increment done_count, which wraps at 2^CNT_WIDTH.
  - The next accept can occur in the cycle after the handshake, so throughput is at most one operation per 3 cycles.
- Latency: request accepted at edge T, rsp_valid is high from T+2 onward.
- alu_oe=0 in IDLE and RESP. alu_a, alu_b and alu_cmd hold their last values; their content is don't-care while alu_oe=0.
- Requester inputs are sampled only on the accept edge. Changes while not ready are ignored.
- The ALU result for X-producing codes is never used: all paths that produce X are screened as errors.
- Reset (rst=1 at an edge, from any state including EXEC or RESP):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, done_count=0.
  - alu_oe=0, alu_a=0, alu_b=0, alu_cmd=0.
  - Any in-flight operation is dropped with no response.
- Ready outputs are 0 while rst is high.

Test Plan:
- Single op: r0 ADD (cmd 0x00), a=0x12, b=0x34, rsp_ready=1 → r0_ready in accept cycle; alu_oe=1 one cycle later; rsp_valid at T+2 with rsp_id=0, rsp_data=0x0046, rsp_err=0; done_count=1.
- Tie round-robin: both valid continuously, r0 MUL 0xFF×0xFF, r1 SUB 5-7 → grant order r0, r1, r0, r1 with data 0xFE01, 0xFFFE (r1 SUB: 16-bit wrap), repeating. No cycle has both readies high.
- Errors: r1 DIV a=9, b=0, then r1 cmd 0x08 → each returns rsp_err=1, rsp_data=0; alu_oe stays 0 throughout; DIV 9/2 then returns 0x0004 with err=0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while r0 and r1 are both valid → rsp fields stable, both readies 0; after the handshake, next accept happens the following cycle and done_count increments once.
- Reset mid-op: assert rst during EXEC, then during RESP → next cycle rsp_valid=0, alu_oe=0, done_count=0; first post-reset tie is granted to r0.
- Counter wrap: CNT_WIDTH=4, 17 completed ops → done_count reads 1.
